// File: rtl/bitstream_carry_resolver_pkg.sv
// Shared types and constants for the bitstream carry resolver.
package carry_resolver_pkg;
  localparam int BYTE_WIDTH     = 8;
  localparam int PRE_WORD_WIDTH = 9;

  localparam logic [1:0] FLAG_NONE = 2'b00;
  localparam logic [1:0] FLAG_ONE  = 2'b01;
  localparam logic [1:0] FLAG_TWO  = 2'b10;

  typedef logic [PRE_WORD_WIDTH-1:0] pre_word_t;
  typedef logic [BYTE_WIDTH-1:0]     byte_t;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_HOLD,
    S_EMIT_PEND,
    S_EMIT_RUN
  } state_t;
endpackage

// File: rtl/bitstream_carry_resolver_if.sv
// Pre-bitstream input, byte output stream and status for the carry resolver.
// CARRY_RESOLVER_STATS_EN adds the stat_bytes / stat_carries counters.
interface bitstream_carry_resolver_if #(parameter int WORD_WIDTH = 16);
  logic                  in_valid;
  logic [1:0]            in_flag;
  logic [WORD_WIDTH-1:0] in_bit_1;
  logic [WORD_WIDTH-1:0] in_bit_2;
  logic                  in_ready;
  logic                  flush;
  logic [7:0]            out_byte;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic                  flush_done;
  logic                  err;
`ifdef CARRY_RESOLVER_STATS_EN
  logic [31:0]           stat_bytes;
  logic [15:0]           stat_carries;

  modport master (output in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
                  input  in_ready, out_byte, out_valid, out_last, flush_done, err,
                         stat_bytes, stat_carries);
  modport slave  (input  in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
                  output in_ready, out_byte, out_valid, out_last, flush_done, err,
                         stat_bytes, stat_carries);
`else
  modport master (output in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
                  input  in_ready, out_byte, out_valid, out_last, flush_done, err);
  modport slave  (input  in_valid, in_flag, in_bit_1, in_bit_2, flush, out_ready,
                  output in_ready, out_byte, out_valid, out_last, flush_done, err);
`endif
endinterface

// File: rtl/bitstream_carry_resolver_precarry_fifo.sv
// Dual-write single-read FIFO of 9-bit pre-bitstream words. Port 2 is only
// written together with port 1 and lands behind it. Caller guards overflow.
module precarry_fifo
  import carry_resolver_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_1,
  input  pre_word_t        wr_data_1,
  input  logic             wr_en_2,
  input  pre_word_t        wr_data_2,
  input  logic             rd_en,
  output pre_word_t        rd_data,
  output logic [CNT_W-1:0] count
);
  pre_word_t        mem_q [DEPTH];
  pre_word_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr_p1;
  logic [CNT_W-1:0] count_q, count_d, n_wr;

  assign wr_ptr_p1 = wr_ptr_q + 1'b1;
  assign rd_data   = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Next storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    n_wr     = '0;
    if (wr_en_1) begin
      mem_d[wr_ptr_q] = wr_data_1;
      wr_ptr_d        = wr_ptr_p1;
      n_wr            = CNT_W'(1);
      if (wr_en_2) begin
        mem_d[wr_ptr_p1] = wr_data_2;
        wr_ptr_d         = wr_ptr_p1 + 1'b1;
        n_wr             = CNT_W'(2);
      end
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + n_wr - CNT_W'(rd_en);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/bitstream_carry_resolver.sv
// Carry resolver: buffers pre-bitstream words, folds carries back over pending
// 0xFF runs and emits final bytes on a valid/ready stream, with frame flush.
// CARRY_RESOLVER_STATS_EN adds byte and carry counters.
module bitstream_carry_resolver
  import carry_resolver_pkg::*;
#(
  parameter int WORD_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int RUN_CNT_WIDTH = 16
) (
  input logic                      general_clk,
  input logic                      reset,
  bitstream_carry_resolver_if.slave bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);

  state_t                   state_q, state_d;
  byte_t                    pend_q, pend_d, emit_byte_q, emit_byte_d, run_byte_q, run_byte_d;
  logic [RUN_CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic flush_req_q, flush_req_d, finishing_q, finishing_d;
  logic flush_done_q, flush_done_d, err_q, err_d;
  logic pop, wr_en_1, wr_en_2, in_ready, out_valid, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  pre_word_t head;
  logic unused_hi;

  assign unused_hi = ^{bus.in_bit_1[WORD_WIDTH-1:PRE_WORD_WIDTH],
                       bus.in_bit_2[WORD_WIDTH-1:PRE_WORD_WIDTH]};

  // Refuse input while a flush drains so the frame boundary stays clean.
  assign in_ready   = (fifo_count <= READY_MAX) && !flush_req_q;
  assign fifo_empty = (fifo_count == '0);
  assign wr_en_1 = bus.in_valid && in_ready &&
                   (bus.in_flag == FLAG_ONE || bus.in_flag == FLAG_TWO);
  assign wr_en_2 = bus.in_valid && in_ready && (bus.in_flag == FLAG_TWO);

  precarry_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (general_clk),
    .rst       (reset),
    .wr_en_1   (wr_en_1),
    .wr_data_1 (bus.in_bit_1[PRE_WORD_WIDTH-1:0]),
    .wr_en_2   (wr_en_2),
    .wr_data_2 (bus.in_bit_2[PRE_WORD_WIDTH-1:0]),
    .rd_en     (pop),
    .rd_data   (head),
    .count     (fifo_count)
  );

  assign out_valid      = (state_q == S_EMIT_PEND) || (state_q == S_EMIT_RUN);
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.flush_done = flush_done_q;
  assign bus.err        = err_q;
  assign bus.out_last   = finishing_q &&
                          ((state_q == S_EMIT_PEND && run_cnt_q == '0) ||
                           (state_q == S_EMIT_RUN  && run_cnt_q == RUN_CNT_WIDTH'(1)));

  // Output byte select; zero when idle.
  always_comb begin
    bus.out_byte = '0;
    if (state_q == S_EMIT_PEND)     bus.out_byte = emit_byte_q;
    else if (state_q == S_EMIT_RUN) bus.out_byte = run_byte_q;
  end

  // Next state, pop control, run counting and flush sequencing.
  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    emit_byte_d  = emit_byte_q;
    run_byte_d   = run_byte_q;
    run_cnt_d    = run_cnt_q;
    flush_req_d  = flush_req_q;
    finishing_d  = finishing_q;
    flush_done_d = 1'b0;
    err_d        = err_q;
    pop          = 1'b0;
    if (bus.flush) flush_req_d = 1'b1;
    if (bus.in_valid && bus.in_flag == 2'b11) err_d = 1'b1;
    if (bus.in_valid && bus.in_flag != FLAG_NONE && !in_ready) err_d = 1'b1;
    case (state_q)
      S_EMPTY: begin
        if (!fifo_empty) begin
          // First byte of a frame has nothing behind it to carry into.
          pop     = 1'b1;
          pend_d  = head[BYTE_WIDTH-1:0];
          state_d = S_HOLD;
        end else if (flush_req_q) begin
          flush_done_d = 1'b1;
          flush_req_d  = 1'b0;
        end
      end
      S_HOLD: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head == 9'h0FF) begin
            if (&run_cnt_q) err_d = 1'b1;
            else            run_cnt_d = run_cnt_q + 1'b1;
          end else begin
            emit_byte_d = pend_q + {7'b0, head[8]};
            run_byte_d  = head[8] ? 8'h00 : 8'hFF;
            pend_d      = head[BYTE_WIDTH-1:0];
            state_d     = S_EMIT_PEND;
          end
        end else if (flush_req_q) begin
          emit_byte_d = pend_q;
          run_byte_d  = 8'hFF;
          finishing_d = 1'b1;
          state_d     = S_EMIT_PEND;
        end
      end
      S_EMIT_PEND: begin
        if (bus.out_ready) begin
          if (run_cnt_q != '0) state_d = S_EMIT_RUN;
          else if (finishing_q) begin
            state_d      = S_EMPTY;
            finishing_d  = 1'b0;
            flush_done_d = 1'b1;
            flush_req_d  = 1'b0;
          end else state_d = S_HOLD;
        end
      end
      S_EMIT_RUN: begin
        if (bus.out_ready) begin
          run_cnt_d = run_cnt_q - 1'b1;
          if (run_cnt_q == RUN_CNT_WIDTH'(1)) begin
            if (finishing_q) begin
              state_d      = S_EMPTY;
              finishing_d  = 1'b0;
              flush_done_d = 1'b1;
              flush_req_d  = 1'b0;
            end else state_d = S_HOLD;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      pend_q       <= '0;
      emit_byte_q  <= '0;
      run_byte_q   <= '0;
      run_cnt_q    <= '0;
      flush_req_q  <= 1'b0;
      finishing_q  <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      emit_byte_q  <= emit_byte_d;
      run_byte_q   <= run_byte_d;
      run_cnt_q    <= run_cnt_d;
      flush_req_q  <= flush_req_d;
      finishing_q  <= finishing_d;
      flush_done_q <= flush_done_d;
      err_q        <= err_d;
    end
  end

`ifdef CARRY_RESOLVER_STATS_EN
  logic [31:0] stat_bytes_q, stat_bytes_d;
  logic [15:0] stat_carries_q, stat_carries_d;

  assign bus.stat_bytes   = stat_bytes_q;
  assign bus.stat_carries = stat_carries_q;

  // Wrapping counters of output handshakes and popped carry words.
  always_comb begin
    stat_bytes_d   = stat_bytes_q + {31'b0, out_valid && bus.out_ready};
    stat_carries_d = stat_carries_q + {15'b0, pop && head[8]};
  end

  // Statistics registers.
  always_ff @(posedge general_clk or posedge reset) begin
    if (reset) begin
      stat_bytes_q   <= '0;
      stat_carries_q <= '0;
    end else begin
      stat_bytes_q   <= stat_bytes_d;
      stat_carries_q <= stat_carries_d;
    end
  end
`endif
endmodule

// File: tb/tb_bitstream_carry_resolver.sv
// Directed bench for bitstream_carry_resolver: table of frames plus
// hand sequences for backpressure, FIFO fill, errors and mid-run reset.
module tb_bitstream_carry_resolver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitstream_carry_resolver_if #(.WORD_WIDTH(16)) bus ();

  bitstream_carry_resolver #(.WORD_WIDTH(16), .FIFO_DEPTH(8), .RUN_CNT_WIDTH(16)) dut (
    .general_clk (clk),
    .reset       (rst),
    .bus         (bus)
  );

  typedef struct {
    int              n;
    logic [3:0][8:0] w;
    int              nb;
    logic [8:0][7:0] b;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  // Push one word (flag 01); optionally raise flush in the same cycle.
  task automatic push_word(input logic [8:0] w, input logic fl);
    bus.in_valid = 1'b1;
    bus.in_flag  = 2'b01;
    bus.in_bit_1 = {7'b0, w};
    bus.flush    = fl;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    bus.flush    = 1'b0;
  endtask

  // Collect bytes until flush_done; check values, out_last and done timing.
  task automatic collect(input string tag, input int nb, input logic [8:0][7:0] eb);
    int  got = 0;
    int  last_cyc = -1;
    int  done_cyc = -1;
    for (int c = 0; c < 80 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        if (got < nb) begin
          chk($sformatf("%s byte%0d", tag, got), int'(bus.out_byte), int'(eb[got]));
          chk($sformatf("%s last%0d", tag, got), int'(bus.out_last), (got == nb - 1) ? 1 : 0);
        end
        last_cyc = c;
        got++;
      end
      if (bus.flush_done) done_cyc = c;
      @(posedge clk); #1;
      bus.flush = 1'b0;
    end
    chk({tag, " flush_done seen"}, (done_cyc >= 0) ? 1 : 0, 1);
    chk({tag, " byte count"}, got, nb);
    if (nb > 0 && done_cyc >= 0)
      chk({tag, " done delay"}, done_cyc - last_cyc, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0][7:0] eb;
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_flag   = 2'b00;
    bus.in_bit_1  = '0;
    bus.in_bit_2  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    for (int i = 0; i < 6; i++) begin
      vt[i].n = 0; vt[i].w = '0; vt[i].nb = 0; vt[i].b = '0;
    end
    vt[0].n = 2; vt[0].w[0] = 9'h012; vt[0].w[1] = 9'h034;
    vt[0].nb = 2; vt[0].b[0] = 8'h12; vt[0].b[1] = 8'h34;
    vt[1].n = 4; vt[1].w[0] = 9'h012; vt[1].w[1] = 9'h0FF; vt[1].w[2] = 9'h0FF; vt[1].w[3] = 9'h105;
    vt[1].nb = 4; vt[1].b[0] = 8'h13; vt[1].b[1] = 8'h00; vt[1].b[2] = 8'h00; vt[1].b[3] = 8'h05;
    vt[2].n = 3; vt[2].w[0] = 9'h0AA; vt[2].w[1] = 9'h0FF; vt[2].w[2] = 9'h0FF;
    vt[2].nb = 3; vt[2].b[0] = 8'hAA; vt[2].b[1] = 8'hFF; vt[2].b[2] = 8'hFF;
    vt[3].n = 1; vt[3].w[0] = 9'h155;
    vt[3].nb = 1; vt[3].b[0] = 8'h55;
    vt[4].n = 2; vt[4].w[0] = 9'h0FF; vt[4].w[1] = 9'h100;
    vt[4].nb = 2; vt[4].b[0] = 8'h00; vt[4].b[1] = 8'h00;
    vt[5].n = 3; vt[5].w[0] = 9'h07F; vt[5].w[1] = 9'h0FF; vt[5].w[2] = 9'h003;
    vt[5].nb = 3; vt[5].b[0] = 8'h7F; vt[5].b[1] = 8'hFF; vt[5].b[2] = 8'h03;

    // Reset state.
    @(posedge clk); @(posedge clk); #1;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_byte", int'(bus.out_byte), 0);
    chk("rst out_last", int'(bus.out_last), 0);
    chk("rst flush_done", int'(bus.flush_done), 0);
    chk("rst err", int'(bus.err), 0);
    chk("rst in_ready", int'(bus.in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of frames, each closed by a flush on its last word.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vt[v].n; i++) push_word(vt[v].w[i], i == vt[v].n - 1);
      collect($sformatf("vec%0d", v), vt[v].nb, vt[v].b);
    end
    chk("vec err", int'(bus.err), 0);

    // Two words in one cycle, sink stalled for 5 cycles.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_flag   = 2'b10;
    bus.in_bit_1  = 16'h0001;
    bus.in_bit_2  = 16'h0002;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall valid%0d", i), int'(bus.out_valid), 1);
      chk($sformatf("stall byte%0d", i), int'(bus.out_byte), 8'h01);
      @(posedge clk);
    end
    #1;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    eb = '0; eb[0] = 8'h01; eb[1] = 8'h02;
    collect("stall", 2, eb);

    // Fill the FIFO behind a stalled sink, then a dropped write.
    do_reset();
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (!bus.in_ready) break;
      push_word(9'h011, 1'b0);
      acc++;
    end
    chk("fill accepted", acc, 9);
    chk("fill in_ready", int'(bus.in_ready), 0);
    chk("fill err", int'(bus.err), 0);
    bus.in_valid = 1'b1;
    bus.in_flag  = 2'b01;
    bus.in_bit_1 = 16'h0022;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    chk("drop err", int'(bus.err), 1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    eb = '0;
    for (int i = 0; i < 9; i++) eb[i] = 8'h11;
    collect("fill", 9, eb);

    // Reserved flag pushes nothing and sets err.
    do_reset();
    chk("resv err before", int'(bus.err), 0);
    bus.in_valid = 1'b1;
    bus.in_flag  = 2'b11;
    bus.in_bit_1 = 16'h0033;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_flag  = 2'b00;
    chk("resv err", int'(bus.err), 1);
    bus.flush = 1'b1;
    collect("resv", 0, '0);

    // Reset while emitting the 0xFF run.
    do_reset();
    bus.out_ready = 1'b0;
    push_word(9'h0AA, 1'b0);
    push_word(9'h0FF, 1'b0);
    push_word(9'h0FF, 1'b0);
    push_word(9'h005, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    chk("run pend valid", int'(bus.out_valid), 1);
    chk("run pend byte", int'(bus.out_byte), 8'hAA);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("run ff valid", int'(bus.out_valid), 1);
    chk("run ff byte", int'(bus.out_byte), 8'hFF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(bus.out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    collect("midrst", 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
